// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: FSM state type and default constants for frequency_meter.
package freq_meter_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
  localparam int GATE_CYCLES_DEF = 50_000_000;
  localparam int CNT_W_DEF = 27;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus one-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic pulse
);
  logic [2:0] sr;
  always_ff @(posedge clk)
    if (!resetn) sr <= '0;
    else sr <= {sr[1:0], d};
  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/frequency_meter.sv
// frequency_meter: counts sig_in rising edges over a GATE_CYCLES window.
// Define FREQUENCY_METER_AUTORUN_EN for back-to-back windows without start.
module frequency_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_50m,
  input  logic             resetn,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             ovf
);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
`ifdef FREQUENCY_METER_AUTORUN_EN
  localparam logic AUTORUN = 1'b1;
`else
  localparam logic AUTORUN = 1'b0;
`endif
  state_t state;
  logic [GW-1:0] gate;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic hit;
  sync_edge_detect u_sync (.clk(clk_50m), .resetn(resetn), .d(sig_in), .pulse(hit));
  // saturating increment; the final gate cycle's edge lands in the loaded result
  assign cnt_nxt = cnt + CNT_W'(hit && !(&cnt));
  assign busy = (state == MEASURE);
  always_ff @(posedge clk_50m)
    if (!resetn) begin
      state <= IDLE;
      gate <= '0;
      cnt <= '0;
      freq <= '0;
      freq_valid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: if (AUTORUN || start) begin
          state <= MEASURE;
          gate <= '0;
          cnt <= '0;
        end
        MEASURE: begin
          cnt <= cnt_nxt;
          gate <= gate + 1'b1;
          if (gate == GATE_LAST) begin
            state <= DONE;
            freq <= cnt_nxt;
            ovf <= &cnt_nxt;
            freq_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= AUTORUN ? MEASURE : IDLE;
          gate <= '0;
          cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_frequency_meter.sv
// tb_frequency_meter: directed checks on an 8-bit and a 4-bit counter instance.
module tb_frequency_meter;
  logic clk = 1'b0, resetn = 1'b0, sig_in = 1'b0, start = 1'b0;
  logic busy8, fv8, ovf8, busy4, fv4, ovf4;
  logic [7:0] freq8;
  logic [3:0] freq4;
  int vectors = 0, errors = 0, half = 0, ph = 0;
  always #5 clk = ~clk;
  frequency_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut8 (.clk_50m(clk), .resetn(resetn),
    .sig_in(sig_in), .start(start), .busy(busy8), .freq(freq8), .freq_valid(fv8), .ovf(ovf8));
  frequency_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (.clk_50m(clk), .resetn(resetn),
    .sig_in(sig_in), .start(start), .busy(busy4), .freq(freq4), .freq_valid(fv4), .ovf(ovf4));
  // free-running square wave with half-period 'half' cycles; 0 holds sig_in
  always @(negedge clk)
    if (half != 0) begin
      if (ph >= half - 1) begin
        sig_in = ~sig_in;
        ph = 0;
      end else ph++;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic run(input string tag, input int restart_at, input int rise_at,
                     input int e8, input int e4, input logic eo4);
    int nb = 0, nv8 = 0, nv4 = 0;
    logic [7:0] f8 = '1;
    logic [3:0] f4 = '1;
    logic o8 = 1'bx, o4 = 1'bx;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 110; i++) begin
      if (busy8) nb++;
      if (fv8) begin nv8++; f8 = freq8; o8 = ovf8; end
      if (fv4) begin nv4++; f4 = freq4; o4 = ovf4; end
      if (i == rise_at) sig_in = 1'b1;
      start = (i == restart_at);
      tick(1);
    end
    start = 1'b0;
    check({tag, ".busy_cycles"}, nb, 100);
    check({tag, ".valid8"}, nv8, 1);
    check({tag, ".valid4"}, nv4, 1);
    check({tag, ".freq8"}, f8, e8);
    check({tag, ".ovf8"}, o8, 0);
    check({tag, ".freq4"}, f4, e4);
    check({tag, ".ovf4"}, o4, eo4);
    check({tag, ".hold8"}, freq8, e8);
    check({tag, ".idle"}, busy8, 0);
  endtask
  initial begin
    tick(3);
    check("rst.busy", busy8, 0);
    check("rst.valid", fv8, 0);
    check("rst.freq", freq8, 0);
    check("rst.ovf", ovf4, 0);
    resetn = 1'b1;
`ifdef FREQUENCY_METER_AUTORUN_EN
    begin
      int last = -1, seen = 0;
      half = 5;
      for (int i = 0; i < 520; i++) begin
        if (fv8) begin
          if (seen > 0) begin
            check("auto.period", i - last, 101);
            check("auto.freq", freq8, 10);
          end
          last = i;
          seen++;
        end
        tick(1);
      end
      check("auto.windows", seen, 5);
    end
`else
    half = 5; tick(30);
    run("p10", -1, -1, 10, 10, 1'b0);
    half = 0; sig_in = 1'b0; tick(10);
    run("const", 20, -1, 0, 0, 1'b0);
    tick(5);
    check("const.no_requeue", busy8, 0);
    run("last_gate", -1, 97, 1, 1, 1'b0);
    sig_in = 1'b0; tick(10);
    run("past_gate", -1, 98, 0, 0, 1'b0);
    sig_in = 1'b0;
    half = 2; tick(30);
    run("p4", -1, -1, 25, 15, 1'b1);
    half = 10; tick(30);
    run("p20", -1, -1, 5, 5, 1'b0);
    begin
      int nv = 0, nb = 0;
      start = 1'b1; tick(1); start = 1'b0;
      tick(50);
      check("rst_mid.busy_before", busy8, 1);
      resetn = 1'b0;
      tick(1);
      check("rst_mid.busy", busy8, 0);
      check("rst_mid.freq", freq8, 0);
      check("rst_mid.valid", fv8, 0);
      resetn = 1'b1;
      for (int i = 0; i < 120; i++) begin
        if (fv8) nv++;
        if (busy8) nb++;
        tick(1);
      end
      check("rst_mid.no_valid", nv, 0);
      check("rst_mid.no_busy", nb, 0);
    end
    half = 5; tick(20);
    run("after_rst", -1, -1, 10, 10, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/frequency_meter.md
FREQUENCY_METER -- requirements
Module: frequency_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 50_000_000: clk_50m cycles per measurement window (1 s at 50 MHz); legal range 2..2^27-1.
REQ-002 Parameter CNT_W, default 27: width of the edge counter and of the result.
REQ-003 clk_50m  input  1  sole clock; all logic on posedge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 sig_in  input  1  asynchronous signal to measure, e.g. a divided clock.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 busy  output  1  high while a window is open.
REQ-008 freq  output  CNT_W  rising edges counted in the last completed window (Hz when GATE_CYCLES = 1 s).
REQ-009 freq_valid  output  1  one-cycle pulse when freq is updated.
REQ-010 ovf  output  1  high when the last completed window saturated the counter.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer; a rising edge is sync2 high with a 1-cycle-delayed copy low. Edge-to-count latency: 3 cycles.
REQ-012 FSM states SHALL be IDLE, MEASURE and DONE.
REQ-013 IDLE->MEASURE on start; gate counter loads 0 and edge counter loads 0 on that cycle.
REQ-014 MEASURE SHALL last exactly GATE_CYCLES cycles; each detected edge increments the edge counter.
REQ-015 An edge detected on the last MEASURE cycle SHALL be counted.
REQ-016 MEASURE->DONE after the last gate cycle; in DONE, freq and ovf SHALL be loaded and freq_valid SHALL pulse for 1 cycle.
REQ-017 DONE->IDLE unconditionally after 1 cycle.
REQ-018 The edge counter SHALL saturate at 2^CNT_W-1 and SHALL not wrap; reaching saturation sets the window's overflow flag.
REQ-019 start while in MEASURE or DONE SHALL be ignored and not queued.
REQ-020 freq and ovf SHALL hold their value between updates.
REQ-021 busy SHALL be high exactly in MEASURE.
REQ-022 The maximum countable rate is clk_50m/2; faster inputs alias low. This is a documented limit, not an error.

Reset
REQ-023 While resetn=0 at a clock edge: state=IDLE, freq=0, freq_valid=0, ovf=0, busy=0, both counters=0, synchronizer flops=0.
REQ-024 Reset mid-MEASURE SHALL abandon the window without a freq_valid pulse, and freq SHALL read 0.

Configuration
REQ-025 Macro FREQUENCY_METER_AUTORUN_EN:
  - Defined: DONE goes directly to MEASURE, giving back-to-back windows with no idle gap (period GATE_CYCLES+1), and start is ignored. After reset the FSM passes through IDLE for 1 cycle, then enters MEASURE.
  - Undefined: single-shot behaviour per REQ-013/REQ-017.

Structure
REQ-026 Package freq_meter_pkg SHALL hold the FSM state enum typedef (IDLE, MEASURE, DONE) and the default constants (GATE_CYCLES 50_000_000, CNT_W 27).
REQ-027 One sub-module, sync_edge_detect (2-flop synchronizer plus rising-edge pulse, synchronous active-low reset), SHALL be instantiated once.
REQ-028 The gate counter SHALL be $clog2(GATE_CYCLES+1) bits wide.

Verification (GATE_CYCLES=100, CNT_W=8 unless stated)
REQ-029 sig_in toggling every 5 cycles (period 10), start pulse -> busy high 100 cycles, freq_valid pulse with freq=10, ovf=0.
REQ-030 sig_in held constant, start -> freq=0, ovf=0; a second start during busy is ignored -> exactly one freq_valid pulse.
REQ-031 CNT_W=4, sig_in period 4 (25 edges) -> freq=15, ovf=1; then a period-20 input (5 edges) -> freq=5, ovf=0.
REQ-032 Single rising edge timed to be detected on gate cycle 100 -> counted, freq=1.
REQ-033 resetn low at MEASURE cycle 50 -> no freq_valid, freq=0, busy=0 the cycle after; a following start measures normally.
REQ-034 With FREQUENCY_METER_AUTORUN_EN, period-10 input, no start -> freq_valid every 101 cycles, each with freq=10.
